// File: rtl/usb_bus_master.sv
// usb_bus_master: initiator for the USB-controller-side FPGA bus.
// Runs single register read/write cycles (ADD/BUS_DATA/RD_B/WR_B) from a
// valid/ready command port, and high-speed read bursts (FREAD/FSTROBE/FD_IN)
// from a start/length port. Bus data is split into in/out/oe; the tristate
// buffer lives outside this block.
module usb_bus_master #(
   parameter int unsigned ABUSWIDTH    = 32,
   parameter int unsigned SETUP_CYCLES = 1,
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter int unsigned LENWIDTH     = 16
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST,

   input  logic                 CMD_VALID,
   output logic                 CMD_READY,
   input  logic                 CMD_WR,
   input  logic [ABUSWIDTH-1:0] CMD_ADD,
   input  logic [7:0]           CMD_DATA,
   output logic                 RSP_VALID,
   output logic [7:0]           RSP_DATA,

   input  logic                 BURST_START,
   input  logic [LENWIDTH-1:0]  BURST_LEN,
   output logic                 BURST_BUSY,
   output logic                 FD_VALID,
   output logic [7:0]           FD_DATA,

   output logic [ABUSWIDTH-1:0] ADD,
   output logic [7:0]           BUS_DATA_OUT,
   output logic                 BUS_DATA_OE,
   input  logic [7:0]           BUS_DATA_IN,
   output logic                 RD_B,
   output logic                 WR_B,

   input  logic [7:0]           FD_IN,
   output logic                 FREAD,
   output logic                 FSTROBE,
   output logic                 FMODE
);

   // Phase counter only needs to reach the longer of the setup/strobe phases.
   localparam int unsigned CNT_MAX = (SETUP_CYCLES > WAIT_CYCLES) ? SETUP_CYCLES : WAIT_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      BSETUP,
      BSTROBE,
      BGAP
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [LENWIDTH-1:0] remaining;
   logic                wr_q;

   logic                cmd_accept;
   logic                burst_accept;

   // A command wins over a burst request raised in the same cycle.
   assign cmd_accept   = CMD_VALID & CMD_READY;
   assign burst_accept = (state == IDLE) & ~CMD_VALID & BURST_START & (BURST_LEN != '0);

   // Sequencer: state, phase counters and every registered bus/handshake output.
   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         state        <= IDLE;
         cnt          <= '0;
         remaining    <= '0;
         wr_q         <= 1'b0;
         CMD_READY    <= 1'b0;
         RSP_VALID    <= 1'b0;
         RSP_DATA     <= '0;
         BURST_BUSY   <= 1'b0;
         FD_VALID     <= 1'b0;
         FD_DATA      <= '0;
         ADD          <= '0;
         BUS_DATA_OUT <= '0;
         BUS_DATA_OE  <= 1'b0;
         RD_B         <= 1'b1;
         WR_B         <= 1'b1;
         FREAD        <= 1'b0;
         FSTROBE      <= 1'b0;
         FMODE        <= 1'b0;
      end else begin
         // Response strobes are single-cycle pulses.
         RSP_VALID <= 1'b0;
         FD_VALID  <= 1'b0;

         case (state)
            IDLE: begin
               if (cmd_accept) begin
                  state     <= SETUP;
                  cnt       <= '0;
                  wr_q      <= CMD_WR;
                  ADD       <= CMD_ADD;
                  CMD_READY <= 1'b0;
                  if (CMD_WR) begin
                     BUS_DATA_OUT <= CMD_DATA;
                     BUS_DATA_OE  <= 1'b1;
                  end
               end else if (burst_accept) begin
                  state      <= BSETUP;
                  remaining  <= BURST_LEN;
                  CMD_READY  <= 1'b0;
                  FMODE      <= 1'b1;
                  FREAD      <= 1'b1;
                  BURST_BUSY <= 1'b1;
               end else begin
                  CMD_READY <= 1'b1;
               end
            end

            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state <= STROBE;
                  cnt   <= '0;
                  if (wr_q) WR_B <= 1'b0;
                  else      RD_B <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            STROBE: begin
               if (cnt == WAIT_LAST) begin
                  // Read data is taken on the edge that releases the strobe.
                  state <= HOLD;
                  cnt   <= '0;
                  WR_B  <= 1'b1;
                  RD_B  <= 1'b1;
                  if (!wr_q) begin
                     RSP_DATA  <= BUS_DATA_IN;
                     RSP_VALID <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            HOLD: begin
               state       <= IDLE;
               BUS_DATA_OE <= 1'b0;
               CMD_READY   <= 1'b1;
            end

            BSETUP: begin
               state   <= BSTROBE;
               FSTROBE <= 1'b1;
            end

            BSTROBE: begin
               state   <= BGAP;
               FSTROBE <= 1'b0;
            end

            BGAP: begin
               // Count down to 1 rather than 0 so a full-scale length never wraps.
               FD_DATA   <= FD_IN;
               FD_VALID  <= 1'b1;
               remaining <= remaining - LENWIDTH'(1);
               if (remaining == LENWIDTH'(1)) begin
                  state      <= IDLE;
                  FREAD      <= 1'b0;
                  FMODE      <= 1'b0;
                  BURST_BUSY <= 1'b0;
                  CMD_READY  <= 1'b1;
               end else begin
                  state   <= BSTROBE;
                  FSTROBE <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_bus_master.sv
// Directed bench for usb_bus_master: scoreboard queues for read and burst data,
// cycle-accurate strobe timing checks, and bus invariants checked every cycle.
module tb_usb_bus_master;

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 16;

   logic          BUS_CLK = 1'b0;
   logic          BUS_RST;
   logic          CMD_VALID;
   logic          CMD_READY;
   logic          CMD_WR;
   logic [AW-1:0] CMD_ADD;
   logic [7:0]    CMD_DATA;
   logic          RSP_VALID;
   logic [7:0]    RSP_DATA;
   logic          BURST_START;
   logic [LW-1:0] BURST_LEN;
   logic          BURST_BUSY;
   logic          FD_VALID;
   logic [7:0]    FD_DATA;
   logic [AW-1:0] ADD;
   logic [7:0]    BUS_DATA_OUT;
   logic          BUS_DATA_OE;
   logic [7:0]    BUS_DATA_IN;
   logic          RD_B;
   logic          WR_B;
   logic [7:0]    FD_IN;
   logic          FREAD;
   logic          FSTROBE;
   logic          FMODE;

   always #5 BUS_CLK = ~BUS_CLK;

   usb_bus_master #(
      .ABUSWIDTH    (AW),
      .SETUP_CYCLES (1),
      .WAIT_CYCLES  (2),
      .LENWIDTH     (LW)
   ) dut (
      .BUS_CLK      (BUS_CLK),
      .BUS_RST      (BUS_RST),
      .CMD_VALID    (CMD_VALID),
      .CMD_READY    (CMD_READY),
      .CMD_WR       (CMD_WR),
      .CMD_ADD      (CMD_ADD),
      .CMD_DATA     (CMD_DATA),
      .RSP_VALID    (RSP_VALID),
      .RSP_DATA     (RSP_DATA),
      .BURST_START  (BURST_START),
      .BURST_LEN    (BURST_LEN),
      .BURST_BUSY   (BURST_BUSY),
      .FD_VALID     (FD_VALID),
      .FD_DATA      (FD_DATA),
      .ADD          (ADD),
      .BUS_DATA_OUT (BUS_DATA_OUT),
      .BUS_DATA_OE  (BUS_DATA_OE),
      .BUS_DATA_IN  (BUS_DATA_IN),
      .RD_B         (RD_B),
      .WR_B         (WR_B),
      .FD_IN        (FD_IN),
      .FREAD        (FREAD),
      .FSTROBE      (FSTROBE),
      .FMODE        (FMODE)
   );

   int         total = 0;
   int         bad   = 0;
   logic [7:0] rsp_q[$];
   logic [7:0] fd_q[$];
   logic [7:0] fd_base = 8'h00;

   // Responder: presents the next burst word after each FSTROBE it sees.
   initial begin
      logic [7:0] widx;
      FD_IN = 8'h00;
      widx  = 8'h00;
      forever begin
         @(negedge BUS_CLK);
         if (!FREAD) begin
            widx = 8'h00;
         end else if (FSTROBE) begin
            FD_IN = fd_base + widx;
            widx  = widx + 8'h01;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample just after the edge; bus invariants every cycle.
   task automatic tick();
      @(posedge BUS_CLK);
      #1;
      chk("inv_rd_wr_not_both_low", 64'(RD_B | WR_B), 64'(1));
      chk("inv_fstrobe_needs_fread", 64'(FSTROBE & ~FREAD), 64'(0));
   endtask

   task automatic pop_rsp();
      logic [7:0] e;
      chk("rsp_q_nonempty", 64'(rsp_q.size() != 0), 64'(1));
      if (rsp_q.size() != 0) begin
         e = rsp_q.pop_front();
         chk("rsp_data", 64'(RSP_DATA), 64'(e));
      end
   endtask

   task automatic pop_fd();
      logic [7:0] e;
      chk("fd_q_nonempty", 64'(fd_q.size() != 0), 64'(1));
      if (fd_q.size() != 0) begin
         e = fd_q.pop_front();
         chk("fd_data", 64'(FD_DATA), 64'(e));
      end
   endtask

   // Single write; cycle c counts edges after the acceptance edge.
   task automatic run_write(input logic [AW-1:0] a, input logic [7:0] d);
      CMD_VALID = 1'b1; CMD_WR = 1'b1; CMD_ADD = a; CMD_DATA = d;
      tick();
      CMD_VALID = 1'b0; BURST_START = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) tick();
         chk("wr_wr_b",  64'(WR_B), 64'(!(c == 2 || c == 3)));
         chk("wr_rd_b",  64'(RD_B), 64'(1));
         chk("wr_oe",    64'(BUS_DATA_OE), 64'(c <= 4));
         chk("wr_ready", 64'(CMD_READY), 64'(c == 5));
         chk("wr_fread", 64'(FREAD), 64'(0));
         if (c <= 4) begin
            chk("wr_add",  64'(ADD), 64'(a));
            chk("wr_data", 64'(BUS_DATA_OUT), 64'(d));
         end
      end
   endtask

   // Single read with the responder driving d on BUS_DATA_IN.
   task automatic run_read(input logic [AW-1:0] a, input logic [7:0] d);
      BUS_DATA_IN = d;
      rsp_q.push_back(d);
      CMD_VALID = 1'b1; CMD_WR = 1'b0; CMD_ADD = a;
      tick();
      CMD_VALID = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) tick();
         chk("rd_rd_b",     64'(RD_B), 64'(!(c == 2 || c == 3)));
         chk("rd_wr_b",     64'(WR_B), 64'(1));
         chk("rd_oe",       64'(BUS_DATA_OE), 64'(0));
         chk("rd_rsp_valid", 64'(RSP_VALID), 64'(c == 4));
         chk("rd_ready",    64'(CMD_READY), 64'(c == 5));
         if (RSP_VALID) pop_rsp();
         if (c <= 4) chk("rd_add", 64'(ADD), 64'(a));
      end
      BUS_DATA_IN = 8'hFF;
      tick();
      chk("rd_rsp_hold", 64'(RSP_DATA), 64'(d));
   endtask

   // Burst of n words; ends on the first IDLE cycle (last FD_VALID).
   task automatic run_burst(input int n, input logic [7:0] base);
      int strobes;
      strobes = 0;
      fd_base = base;
      for (int i = 0; i < n; i++) fd_q.push_back(base + 8'(i));
      BURST_LEN = LW'(n); BURST_START = 1'b1;
      tick();
      BURST_START = 1'b0;
      for (int c = 1; c <= 2 * n + 2; c++) begin
         if (c > 1) tick();
         chk("b_fread",   64'(FREAD), 64'(c <= 2 * n + 1));
         chk("b_fmode",   64'(FMODE), 64'(c <= 2 * n + 1));
         chk("b_busy",    64'(BURST_BUSY), 64'(c <= 2 * n + 1));
         chk("b_fstrobe", 64'(FSTROBE), 64'(c % 2 == 0 && c >= 2 && c <= 2 * n));
         chk("b_fd_valid", 64'(FD_VALID), 64'(c % 2 == 0 && c >= 4 && c <= 2 * n + 2));
         chk("b_ready",   64'(CMD_READY), 64'(c == 2 * n + 2));
         if (FSTROBE) strobes++;
         if (FD_VALID) pop_fd();
      end
      chk("b_strobe_count", 64'(strobes), 64'(n));
   endtask

   initial begin
      BUS_RST = 1'b1; CMD_VALID = 1'b0; CMD_WR = 1'b0; CMD_ADD = '0; CMD_DATA = '0;
      BURST_START = 1'b0; BURST_LEN = '0; BUS_DATA_IN = '0;
      repeat (3) tick();

      // Reset values
      chk("rst_ready",   64'(CMD_READY), 64'(0));
      chk("rst_rsp_v",   64'(RSP_VALID), 64'(0));
      chk("rst_rsp_d",   64'(RSP_DATA), 64'(0));
      chk("rst_busy",    64'(BURST_BUSY), 64'(0));
      chk("rst_fd_v",    64'(FD_VALID), 64'(0));
      chk("rst_fd_d",    64'(FD_DATA), 64'(0));
      chk("rst_add",     64'(ADD), 64'(0));
      chk("rst_dout",    64'(BUS_DATA_OUT), 64'(0));
      chk("rst_oe",      64'(BUS_DATA_OE), 64'(0));
      chk("rst_rd_b",    64'(RD_B), 64'(1));
      chk("rst_wr_b",    64'(WR_B), 64'(1));
      chk("rst_fread",   64'(FREAD), 64'(0));
      chk("rst_fstrobe", 64'(FSTROBE), 64'(0));
      chk("rst_fmode",   64'(FMODE), 64'(0));
      BUS_RST = 1'b0;
      tick();
      chk("ready_after_rst", 64'(CMD_READY), 64'(1));

      // Single write and read
      run_write(32'h0000_1000, 8'hA5);
      run_read(32'h0000_0004, 8'h3C);

      // Bursts: 4 words, length 0 ignored, length 1
      run_burst(4, 8'h10);
      tick();
      BURST_LEN = '0; BURST_START = 1'b1;
      tick();
      BURST_START = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("len0_fread", 64'(FREAD), 64'(0));
         chk("len0_busy",  64'(BURST_BUSY), 64'(0));
         chk("len0_ready", 64'(CMD_READY), 64'(1));
         tick();
      end
      run_burst(1, 8'h77);
      tick();

      // Command beats a simultaneous burst request; burst retried afterwards,
      // then a read accepted in the same cycle as the last FD_VALID.
      BURST_LEN = LW'(2); BURST_START = 1'b1;
      run_write(32'h0000_0020, 8'h5A);
      run_burst(2, 8'h40);
      run_read(32'h0000_0008, 8'h99);

      // Reset during the 2nd word of an 8-word burst
      fd_base = 8'h80;
      fd_q.push_back(8'h80);
      BURST_LEN = LW'(8); BURST_START = 1'b1;
      tick();
      BURST_START = 1'b0;
      repeat (3) tick();
      chk("abort_b_fd_valid", 64'(FD_VALID), 64'(1));
      if (FD_VALID) pop_fd();
      chk("abort_b_fstrobe", 64'(FSTROBE), 64'(1));
      BUS_RST = 1'b1;
      tick();
      chk("abort_b_fread",   64'(FREAD), 64'(0));
      chk("abort_b_fstrobe0", 64'(FSTROBE), 64'(0));
      chk("abort_b_fmode",   64'(FMODE), 64'(0));
      chk("abort_b_busy",    64'(BURST_BUSY), 64'(0));
      chk("abort_b_fd_v",    64'(FD_VALID), 64'(0));
      chk("abort_b_fd_d",    64'(FD_DATA), 64'(0));
      BUS_RST = 1'b0;
      tick();
      chk("abort_b_ready", 64'(CMD_READY), 64'(1));
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("abort_b_no_fd", 64'(FD_VALID), 64'(0));
         chk("abort_b_idle_fread", 64'(FREAD), 64'(0));
      end

      // Reset during the STROBE of a read
      BUS_DATA_IN = 8'h55;
      CMD_VALID = 1'b1; CMD_WR = 1'b0; CMD_ADD = 32'h0000_000C;
      tick();
      CMD_VALID = 1'b0;
      tick();
      chk("abort_r_strobe", 64'(RD_B), 64'(0));
      BUS_RST = 1'b1;
      tick();
      chk("abort_r_rd_b",  64'(RD_B), 64'(1));
      chk("abort_r_rsp_v", 64'(RSP_VALID), 64'(0));
      chk("abort_r_add",   64'(ADD), 64'(0));
      chk("abort_r_ready", 64'(CMD_READY), 64'(0));
      BUS_RST = 1'b0;
      tick();
      chk("abort_r_ready1", 64'(CMD_READY), 64'(1));
      chk("abort_r_rsp_d",  64'(RSP_DATA), 64'(0));
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("abort_r_no_rsp", 64'(RSP_VALID), 64'(0));
      end

      chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
      chk("fd_q_drained",  64'(fd_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
